bridge_dataslot_read_arb: RTL
=============================

# bridge_dataslot_read_arb

Round-robin arbiter that shares the single core-to-target `core_dataslot_read` request channel among `NUM_CLIENTS` internal requesters (e.g. save-state loader, asset streamer, debug reader). It sits between those clients and the bridge request sequencer. For each transaction it:
- grants one client,
- latches that client's parameters,
- holds the channel `valid` until the bridge reports `done`,
- returns the result to that client with a one-cycle `done` pulse.

## Interface
Parameters:
- `NUM_CLIENTS`, default 4: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 24'd16_000_000: watchdog limit per transaction. Used only when `BRIDGE_DSR_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  bridge/core clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `client_valid`  in  NUM_CLIENTS  level request per client, held until that client's `client_done`.
- `client_param`  in  NUM_CLIENTS x `core_dataslot_read_param_t`  per-client parameters, stable while `client_valid` is high.
- `client_done`  out  NUM_CLIENTS  one-hot, one-cycle completion pulse.
- `client_result`  out  `core_dataslot_read_result_e`  result; meaningful only while any `client_done` bit is high.
- `client_timeout`  out  NUM_CLIENTS  set together with `client_done` when the watchdog aborted the transaction.
- `core_dataslot_read`  interface port  `core_dataslot_read_if`:
  - drives `valid` and `param`;
  - samples `done` and `result`.
- `busy`  out  1  high in every state except IDLE.
- `grant_idx`  out  $clog2(NUM_CLIENTS)  index of the current or last granted client.

## Operation
- States: IDLE, ISSUE, COMPLETE.
- IDLE:
  - If any `client_valid` is high, pick the first set bit scanning upward (with wrap) from `rr_ptr`.
  - Register that client's index into `grant_idx` and its `client_param` into `param_q`.
  - Next state is ISSUE.
- ISSUE:
  - `core_dataslot_read.valid`=1 and `core_dataslot_read.param`=`param_q`.
  - When `done` is 1, register `result` and go to COMPLETE.
- COMPLETE:
  - `client_done[grant_idx]`=1 and `client_result` is the registered result.
  - Set `rr_ptr` to (`grant_idx`+1) mod `NUM_CLIENTS`.
  - Next state is IDLE.
- Clients must clear `valid` on the edge that ends their `client_done` cycle, so a served client is never re-granted from stale `valid`.
- Parameters are captured once, at grant. Later changes to `client_param`, or a client dropping `valid` mid-transaction, do not affect the issued request. Such a client still receives `client_done`.
- A `done` from the channel arriving in IDLE or COMPLETE is ignored.
- `rr_ptr` wraps from `NUM_CLIENTS`-1 to 0. When only one client requests, that client is granted regardless of `rr_ptr`.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `grant_idx`=0, `param_q`=0;
  - `core_dataslot_read.valid`=0;
  - `client_done`=0, `client_timeout`=0, `client_result`=0, `busy`=0.
- Reset mid-transaction: `valid` drops asynchronously and no `client_done` is issued. Clients re-request after reset.
- Latency: `client_valid` seen high in cycle N gives channel `valid` in cycle N+1.
- Channel `done` in cycle K gives `client_done` in cycle K+1. The next grant is decided in cycle K+2, with `valid` in cycle K+3.
- Minimum transaction length, with `done` in the first ISSUE cycle, is 3 cycles.
- The channel's `valid` is registered and glitch-free. `param` is constant while `valid` is high.

## Configuration
- With `BRIDGE_DSR_TIMEOUT_EN` defined:
  - A 24-bit counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When the counter reaches `TIMEOUT_CYCLES`-1 with no `done`, go to COMPLETE with `client_timeout[grant_idx]`=1 and `client_result`=0.
- Without the macro: no counter, `client_timeout` is tied to 0, and ISSUE waits indefinitely.

## Structure
- `bridge_pkg` additions:
  - `dsr_arb_state_e` (2-bit enum for the three states);
  - `DSR_ARB_MAX_CLIENTS`=8;
  - `DSR_ARB_TIMEOUT_W`=24.
- One sub-module: `rr_pick`, a combinational round-robin priority picker taking request vector and pointer and returning `found` and `index`. It is reusable for other bridge channels.

## Test plan
- Single client 2 requests, channel `done` 4 cycles after `valid` → `core.valid` high for exactly 4 cycles; `client_done[2]` one cycle later with `client_result` equal to the driven result; `busy` low after.
- Clients 0, 1 and 3 valid simultaneously with `rr_ptr`=0 → grant order 0, 1, 3, 0, with each re-requesting immediately; no client is starved.
- Client 1 changes `client_param` from 0x10 to 0x20 after grant → channel `param` stays 0x10 for the whole transaction.
- Reset asserted during ISSUE → `core.valid`=0 in the same cycle; no `client_done`; after reset the first grant goes to client 0.
- With `BRIDGE_DSR_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no `done` → `client_done` and `client_timeout` pulse in cycle 9 after `valid`. A late `done` in IDLE is ignored.
- Channel `done` asserted while IDLE with no clients → no state change and no `client_done`.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared bridge types: core_dataslot_read channel payloads and the
// dataslot-read arbiter state encoding and limits.
package bridge_pkg;

    typedef struct packed {
        logic [15:0] slot_id;
        logic [31:0] offset;
    } core_dataslot_read_param_t;

    typedef enum logic [1:0] {
        DSR_RES_NONE    = 2'd0,
        DSR_RES_OK      = 2'd1,
        DSR_RES_ERR     = 2'd2,
        DSR_RES_NO_SLOT = 2'd3
    } core_dataslot_read_result_e;

    typedef enum logic [1:0] {
        DSR_ARB_IDLE     = 2'd0,
        DSR_ARB_ISSUE    = 2'd1,
        DSR_ARB_COMPLETE = 2'd2
    } dsr_arb_state_e;

    localparam int DSR_ARB_MAX_CLIENTS = 8;
    localparam int DSR_ARB_TIMEOUT_W   = 24;

endpackage

// File: rtl/core_dataslot_read_if.sv
// Core-to-target dataslot read request channel: requester drives valid/param,
// target answers with a done pulse carrying the result.
interface core_dataslot_read_if;
    import bridge_pkg::*;

    logic                       valid;
    core_dataslot_read_param_t  param;
    logic                       done;
    core_dataslot_read_result_e result;

    modport arb (output valid, output param, input done, input result);
    modport tgt (input valid, input param, output done, output result);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr with wrap-around. Reusable for any bridge request channel.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                index = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/bridge_dataslot_read_arb.sv
// Round-robin arbiter sharing the core_dataslot_read channel among clients.
// Optional per-transaction watchdog enabled by defining BRIDGE_DSR_TIMEOUT_EN.
module bridge_dataslot_read_arb
    import bridge_pkg::*;
#(
    parameter int                             NUM_CLIENTS    = 4,
    parameter logic [DSR_ARB_TIMEOUT_W-1:0]   TIMEOUT_CYCLES = 24'd16_000_000
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_CLIENTS-1:0]                     client_valid,
    input  core_dataslot_read_param_t [NUM_CLIENTS-1:0] client_param,
    output logic [NUM_CLIENTS-1:0]                     client_done,
    output core_dataslot_read_result_e                 client_result,
    output logic [NUM_CLIENTS-1:0]                     client_timeout,
    core_dataslot_read_if.arb                          core_dataslot_read,
    output logic                                       busy,
    output logic [$clog2(NUM_CLIENTS)-1:0]             grant_idx
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    dsr_arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]           grant_q, grant_d;
    core_dataslot_read_param_t  param_q, param_d;
    core_dataslot_read_result_e result_q, result_d;
    logic                       valid_q, valid_d;
    logic [NUM_CLIENTS-1:0]     done_q, done_d;
    logic                       busy_q, busy_d;
    logic                       pick_found;
    logic [IDX_W-1:0]           pick_idx;

`ifdef BRIDGE_DSR_TIMEOUT_EN
    localparam logic [DSR_ARB_TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - DSR_ARB_TIMEOUT_W'(1);
    logic [DSR_ARB_TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CLIENTS-1:0]       timeout_q, timeout_d;
    assign client_timeout = timeout_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign client_timeout = '0;
`endif

    rr_pick #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick (
        .req   (client_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        param_d  = param_q;
        result_d = result_q;
        valid_d  = valid_q;
        done_d   = '0;
`ifdef BRIDGE_DSR_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = '0;
`endif
        case (state_q)
            DSR_ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    param_d = client_param[pick_idx];
                    valid_d = 1'b1;
                    state_d = DSR_ARB_ISSUE;
`ifdef BRIDGE_DSR_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            DSR_ARB_ISSUE: begin
                if (core_dataslot_read.done) begin
                    result_d        = core_dataslot_read.result;
                    valid_d         = 1'b0;
                    done_d[grant_q] = 1'b1;
                    state_d         = DSR_ARB_COMPLETE;
                end
`ifdef BRIDGE_DSR_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    result_d           = DSR_RES_NONE;
                    valid_d            = 1'b0;
                    done_d[grant_q]    = 1'b1;
                    timeout_d[grant_q] = 1'b1;
                    state_d            = DSR_ARB_COMPLETE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + DSR_ARB_TIMEOUT_W'(1);
                end
`endif
            end
            DSR_ARB_COMPLETE: begin
                // Served client moves to lowest priority for the next scan.
                rr_ptr_d = (grant_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d  = DSR_ARB_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = DSR_ARB_IDLE;
            end
        endcase
        busy_d = (state_d != DSR_ARB_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DSR_ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            param_q  <= '0;
            result_q <= DSR_RES_NONE;
            valid_q  <= 1'b0;
            done_q   <= '0;
            busy_q   <= 1'b0;
`ifdef BRIDGE_DSR_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            param_q  <= param_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef BRIDGE_DSR_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign core_dataslot_read.valid = valid_q;
    assign core_dataslot_read.param = param_q;
    assign client_done   = done_q;
    assign client_result = result_q;
    assign busy          = busy_q;
    assign grant_idx     = grant_q;

endmodule
